// File: rtl/outbox_uart_tx.sv
// outbox_uart_tx: consumer end of the CPU OUTBOX handshake.
// Bytes written with wO (while outFull is low) are queued in a small
// synchronous FIFO and drained onto an 8N1 UART TX line, LSB first.
//
// Ports:
//   clk      system clock
//   i_rst    synchronous active-high reset
//   data     byte to enqueue (R register value)
//   wO       write strobe, one cycle per byte
//   outFull  FIFO holds 2**DEPTH_LOG2 entries
//   outEmpty FIFO holds 0 entries
//   count    current FIFO occupancy
//   tx       UART serial line, idle high, registered
//   tx_busy  a frame is in progress (state other than IDLE)
module outbox_uart_tx #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned BAUD_DIV   = 104
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [7:0]          data,
  input  logic                wO,
  output logic                outFull,
  output logic                outEmpty,
  output logic [DEPTH_LOG2:0] count,
  output logic                tx,
  output logic                tx_busy
);

  localparam int unsigned          DEPTH     = 2 ** DEPTH_LOG2;
  localparam int unsigned          BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]         BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;

  state_t                state_q;
  state_t                state_d;
  logic [BW-1:0]         baud_q;
  logic [BW-1:0]         baud_d;
  logic [2:0]            bit_q;
  logic [2:0]            bit_d;
  logic [7:0]            shift_q;
  logic [7:0]            shift_d;
  logic                  tx_q;
  logic                  tx_d;
  logic                  wr_en;
  logic                  pop;
  logic                  baud_end;

  assign outFull  = (count_q == FULL_CNT);
  assign outEmpty = (count_q == '0);
  assign count    = count_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign wr_en    = wO & ~outFull;
  assign baud_end = (baud_q == BAUD_LAST);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_q follows the current state one cycle later, so the line drops one
  // cycle after the pop that enters START.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!outEmpty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!outEmpty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Directed testbench for outbox_uart_tx (DEPTH_LOG2=2, BAUD_DIV=4).
// A background monitor captures each complete 40-cycle frame seen on tx;
// the test tasks compare captured frames and FIFO flags against
// hand-computed expectations.
module tb_outbox_uart_tx;

  localparam int unsigned DL = 2;
  localparam int unsigned BD = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  data;
  logic        wO;
  logic        outFull;
  logic        outEmpty;
  logic [DL:0] count;
  logic        tx;
  logic        tx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [39:0] fq_bits[$];
  int          fq_start[$];
  logic [7:0]  fq_data[$];

  outbox_uart_tx #(
    .DEPTH_LOG2(DL),
    .BAUD_DIV  (BD)
  ) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .data    (data),
    .wO      (wO),
    .outFull (outFull),
    .outEmpty(outEmpty),
    .count   (count),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected 40-sample image of one frame: 4 start, 8x4 data LSB first, 4 stop.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       f[k] = 1'b0;
      else if (k < 36) f[k] = b[(k - 4) / 4];
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  // Frame capture; a frame whose busy drops early (reset) is discarded.
  initial begin : monitor
    logic [39:0] s;
    logic [7:0]  d;
    int          st;
    bit          ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st   = cyc;
        s    = '0;
        s[0] = tx;
        ok   = 1'b1;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          s[k] = tx;
          if (k < 39 && tx_busy !== 1'b1) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          for (int i = 0; i < 8; i++) d[i] = s[4 + 4 * i + 1];
          fq_bits.push_back(s);
          fq_start.push_back(st);
          fq_data.push_back(d);
        end
      end
    end
  end

  task automatic clear_frames();
    fq_bits.delete();
    fq_start.delete();
    fq_data.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (fq_data.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    wO    = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (outFull !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", outFull); end
    vectors++; if (outEmpty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", outEmpty); end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int w_edge;
    int busy_len;
    int t;
    clear_frames();
    data = 8'h35; wO = 1'b1;
    @(negedge clk);
    wO = 1'b0; w_edge = cyc;
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count1: got %0d want 1", count); end
    vectors++; if (outEmpty !== 1'b0) begin miscompares++; $display("FAIL single_empty0: got %b want 0", outEmpty); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_before: got %b want 1", tx); end
    @(negedge clk);
    vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise: got %b want 1", tx_busy); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_popped: got %0d want 0", count); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_latency: got %b want 1", tx); end
    busy_len = 1; t = 0;
    while (tx_busy === 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
      if (tx_busy === 1'b1) busy_len++;
    end
    vectors++; if (busy_len !== 40) begin miscompares++; $display("FAIL single_busy_len: got %0d want 40", busy_len); end
    @(negedge clk);
    wait_frames(1, 20);
    vectors++; if (fq_data.size() !== 1) begin miscompares++; $display("FAIL single_frames: got %0d want 1", fq_data.size()); end
    if (fq_data.size() >= 1) begin
      vectors++; if (fq_start[0] !== w_edge + 2) begin miscompares++; $display("FAIL single_start: got %0d want %0d", fq_start[0], w_edge + 2); end
      vectors++; if (fq_bits[0] !== frame_bits(8'h35)) begin miscompares++; $display("FAIL single_bits: got %h want %h", fq_bits[0], frame_bits(8'h35)); end
    end
    vectors++; if (outEmpty !== 1'b1) begin miscompares++; $display("FAIL single_empty_end: got %b want 1", outEmpty); end
  endtask

  task automatic test_fill_full();
    int e1 = 0;
    clear_frames();
    for (int i = 1; i <= 5; i++) begin
      data = 8'(i); wO = 1'b1;
      @(negedge clk);
      if (i == 1) e1 = cyc;
    end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count); end
    vectors++; if (outFull !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", outFull); end
    data = 8'hFF; wO = 1'b1;
    @(negedge clk);
    wO = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_drop: got %0d want 4", count); end
    wait_frames(5, 5 * 40 + 40);
    repeat (50) @(negedge clk);
    vectors++; if (fq_data.size() !== 5) begin miscompares++; $display("FAIL fill_frames: got %0d want 5", fq_data.size()); end
    for (int i = 0; i < 5 && i < fq_data.size(); i++) begin
      vectors++; if (fq_data[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL fill_data%0d: got %h want %h", i, fq_data[i], 8'(i + 1)); end
      vectors++; if (fq_bits[i] !== frame_bits(8'(i + 1))) begin miscompares++; $display("FAIL fill_bits%0d: got %h want %h", i, fq_bits[i], frame_bits(8'(i + 1))); end
      vectors++; if (fq_start[i] !== e1 + 2 + 40 * i) begin miscompares++; $display("FAIL fill_start%0d: got %0d want %0d", i, fq_start[i], e1 + 2 + 40 * i); end
    end
    vectors++; if (outEmpty !== 1'b1) begin miscompares++; $display("FAIL fill_empty_end: got %b want 1", outEmpty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_b [4];
    int e1 = 0;
    exp_b[0] = 8'hC3; exp_b[1] = 8'h5A; exp_b[2] = 8'h81; exp_b[3] = 8'h7E;
    clear_frames();
    for (int i = 0; i < 3; i++) begin
      data = exp_b[i]; wO = 1'b1;
      @(negedge clk);
      if (i == 0) e1 = cyc;
    end
    wO = 1'b0;
    while (cyc < e1 + 40) @(negedge clk);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL simul_count_before: got %0d want 2", count); end
    data = exp_b[3]; wO = 1'b1;
    @(negedge clk);
    wO = 1'b0;
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL simul_count_after: got %0d want 2", count); end
    wait_frames(4, 4 * 40 + 40);
    vectors++; if (fq_data.size() !== 4) begin miscompares++; $display("FAIL simul_frames: got %0d want 4", fq_data.size()); end
    for (int i = 0; i < 4 && i < fq_data.size(); i++) begin
      vectors++; if (fq_data[i] !== exp_b[i]) begin miscompares++; $display("FAIL simul_data%0d: got %h want %h", i, fq_data[i], exp_b[i]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_full_handshake();
    int e1 = 0;
    clear_frames();
    for (int i = 0; i < 5; i++) begin
      data = 8'(8'h10 + i); wO = 1'b1;
      @(negedge clk);
      if (i == 0) e1 = cyc;
    end
    wO = 1'b0;
    while (cyc < e1 + 40) @(negedge clk);
    vectors++; if (outFull !== 1'b1) begin miscompares++; $display("FAIL hs_full_held: got %b want 1", outFull); end
    @(negedge clk);
    vectors++; if (outFull !== 1'b0) begin miscompares++; $display("FAIL hs_full_drop: got %b want 0", outFull); end
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL hs_count_pop: got %0d want 3", count); end
    data = 8'h66; wO = 1'b1;
    @(negedge clk);
    wO = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL hs_accept: got %0d want 4", count); end
    vectors++; if (outFull !== 1'b1) begin miscompares++; $display("FAIL hs_full_again: got %b want 1", outFull); end
    wait_frames(6, 6 * 40 + 40);
    vectors++; if (fq_data.size() !== 6) begin miscompares++; $display("FAIL hs_frames: got %0d want 6", fq_data.size()); end
    for (int i = 0; i < 6 && i < fq_data.size(); i++) begin
      vectors++;
      if (fq_data[i] !== ((i == 5) ? 8'h66 : 8'(8'h10 + i))) begin
        miscompares++;
        $display("FAIL hs_data%0d: got %h want %h", i, fq_data[i], (i == 5) ? 8'h66 : 8'(8'h10 + i));
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_pointer_wrap();
    int maxc = 0;
    int k = 0;
    int t;
    clear_frames();
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (count > 3'd1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      for (int j = 0; j < 3; j++) begin
        data = 8'(k * 37 + 9); wO = 1'b1;
        @(negedge clk);
        if (int'(count) > maxc) maxc = int'(count);
        k++;
      end
      wO = 1'b0;
    end
    wait_frames(12, 12 * 40 + 80);
    vectors++; if (fq_data.size() !== 12) begin miscompares++; $display("FAIL wrap_frames: got %0d want 12", fq_data.size()); end
    for (int i = 0; i < 12 && i < fq_data.size(); i++) begin
      vectors++; if (fq_data[i] !== 8'(i * 37 + 9)) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", i, fq_data[i], 8'(i * 37 + 9)); end
    end
    vectors++; if (maxc > 4) begin miscompares++; $display("FAIL wrap_maxcount: got %0d want <=4", maxc); end
    repeat (5) @(negedge clk);
    vectors++; if (outEmpty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty_end: got %b want 1", outEmpty); end
  endtask

  task automatic test_reset_mid_frame();
    int e1 = 0;
    bit tx_low_seen = 1'b0;
    clear_frames();
    data = 8'hA5; wO = 1'b1; @(negedge clk); e1 = cyc;
    data = 8'h11;            @(negedge clk);
    data = 8'h22;            @(negedge clk);
    wO = 1'b0;
    while (cyc < e1 + 17) @(negedge clk);
    vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b want 1", tx_busy); end
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL rstmid_count_before: got %0d want 2", count); end
    i_rst = 1'b1;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", count); end
    vectors++; if (outEmpty !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty: got %b want 1", outEmpty); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
    i_rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low_seen = 1'b1;
    end
    vectors++; if (tx_low_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet: got tx activity want none"); end
    vectors++; if (fq_data.size() !== 0) begin miscompares++; $display("FAIL rstmid_frames: got %0d want 0", fq_data.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_full();
    test_simultaneous();
    test_full_handshake();
    test_pointer_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
